// File: rtl/mapper_ss_sequencer_pkg.sv
// Shared definitions for the mapper save-state sequencer.
// Holds the bus widths, the ack counter width, the FSM state encoding
// and the backing-store address helper.
package mapper_ss_sequencer_pkg;

  localparam int unsigned SS_ADDR_W = 10;
  localparam int unsigned SS_DATA_W = 64;
  localparam int unsigned ACK_CNT_W = 8;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_CLR    = 4'd1,
    ST_S_ADDR = 4'd2,
    ST_S_CAP  = 4'd3,
    ST_S_WR   = 4'd4,
    ST_L_RD   = 4'd5,
    ST_L_WR   = 4'd6,
    ST_APPLY  = 4'd7,
    ST_FIN    = 4'd8
  } state_e;

  // Backing-store word address of a slot; wraps at 10 bits.
  function automatic logic [SS_ADDR_W-1:0] slot_addr(
    input logic [SS_ADDR_W-1:0] base,
    input logic [SS_ADDR_W-1:0] idx
  );
    return base + idx;
  endfunction

endpackage

// File: rtl/mapper_ss_sequencer_ack.sv
// ss_ack_timeout: counts cycles spent waiting for a backing-store ack.
// Ports: clk, reset (async, active-high); arm = request outstanding;
// ack = backing-store ack; expired = wait budget used up this cycle.
module ss_ack_timeout
  import mapper_ss_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic arm,
  input  logic ack,
  output logic expired
);

  logic [ACK_CNT_W-1:0] cnt_q, cnt_d;

  // Counter restarts whenever no request is outstanding or an ack arrives.
  always_comb begin
    cnt_d = cnt_q;
    if (!arm || ack) cnt_d = '0;
    else             cnt_d = cnt_q + ACK_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Fires on the edge that would complete the TIMEOUT-th waiting cycle.
  assign expired = arm && !ack && (cnt_q == ACK_CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mapper_ss_sequencer.sv
// mapper_ss_sequencer: copies mapper save-state slots to a backing store
// (save) or restores them from it (load).
// Ports: clk, reset (async, active-high); start_save/start_load requests;
// busy/done/error status; mem_* backing-store handshake;
// save_state_bus_* mapper save-state bus.
module mapper_ss_sequencer
  import mapper_ss_sequencer_pkg::*;
#(
  parameter int unsigned          NUM_REGS    = 8,
  parameter logic [SS_ADDR_W-1:0] MEM_BASE    = 10'h000,
  parameter int unsigned          ACK_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_save,
  input  logic                 start_load,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [SS_ADDR_W-1:0] mem_addr,
  output logic [SS_DATA_W-1:0] mem_wdata,
  input  logic [SS_DATA_W-1:0] mem_rdata,
  input  logic                 mem_ack,
  output logic [SS_ADDR_W-1:0] save_state_bus_addr,
  output logic [SS_DATA_W-1:0] save_state_bus_din,
  output logic                 save_state_bus_wren,
  output logic                 save_state_bus_rst,
  output logic                 save_state_bus_load,
  input  logic [SS_DATA_W-1:0] save_state_bus_dout
);

  state_e               state_q, state_d;
  logic [SS_ADDR_W-1:0] idx_q, idx_d;
  logic                 error_q, error_d;
  logic [SS_DATA_W-1:0] wdata_q, wdata_d;
  logic [SS_DATA_W-1:0] din_q, din_d;
  logic                 busy_q, done_q, req_q, we_q;
  logic                 wren_q, rst_q, load_q;
  logic [SS_ADDR_W-1:0] mem_addr_q, ss_addr_q;
  logic                 last, ack_ok, expired;

  ss_ack_timeout #(.TIMEOUT(ACK_TIMEOUT)) u_ack_timeout (
    .clk     (clk),
    .reset   (reset),
    .arm     (req_q),
    .ack     (mem_ack),
    .expired (expired)
  );

  assign last   = (idx_q == SS_ADDR_W'(NUM_REGS - 1));
  assign ack_ok = req_q && mem_ack;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    error_d = error_q;
    wdata_d = wdata_q;
    din_d   = din_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_save) begin
          state_d = ST_S_ADDR;
          idx_d   = '0;
          error_d = 1'b0;
        end else if (start_load) begin
          state_d = ST_CLR;
          idx_d   = '0;
          error_d = 1'b0;
        end
      end
      ST_S_ADDR: state_d = ST_S_CAP;
      ST_S_CAP: begin
        wdata_d = save_state_bus_dout;
        state_d = ST_S_WR;
      end
      ST_S_WR: begin
        if (expired) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else if (ack_ok) begin
          if (last) state_d = ST_FIN;
          else begin
            idx_d   = idx_q + SS_ADDR_W'(1);
            state_d = ST_S_ADDR;
          end
        end
      end
      ST_CLR: state_d = ST_L_RD;
      ST_L_RD: begin
        if (expired) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else if (ack_ok) begin
          din_d   = mem_rdata;
          state_d = ST_L_WR;
        end
      end
      ST_L_WR: begin
        if (last) state_d = ST_APPLY;
        else begin
          idx_d   = idx_q + SS_ADDR_W'(1);
          state_d = ST_L_RD;
        end
      end
      ST_APPLY: state_d = ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; strobes decode the upcoming state so
  // they line up with it and are mutually exclusive by construction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      error_q    <= 1'b0;
      wdata_q    <= '0;
      din_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      wren_q     <= 1'b0;
      rst_q      <= 1'b0;
      load_q     <= 1'b0;
      mem_addr_q <= MEM_BASE;
      ss_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      error_q    <= error_d;
      wdata_q    <= wdata_d;
      din_q      <= din_d;
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= (state_d == ST_FIN);
      req_q      <= (state_d == ST_S_WR) || (state_d == ST_L_RD);
      we_q       <= (state_d == ST_S_WR);
      wren_q     <= (state_d == ST_L_WR);
      rst_q      <= (state_d == ST_CLR);
      load_q     <= (state_d == ST_APPLY);
      mem_addr_q <= slot_addr(MEM_BASE, idx_d);
      ss_addr_q  <= idx_d;
    end
  end

  assign busy                = busy_q;
  assign done                = done_q;
  assign error               = error_q;
  assign mem_req             = req_q;
  assign mem_we              = we_q;
  assign mem_addr            = mem_addr_q;
  assign mem_wdata           = wdata_q;
  assign save_state_bus_addr = ss_addr_q;
  assign save_state_bus_din  = din_q;
  assign save_state_bus_wren = wren_q;
  assign save_state_bus_rst  = rst_q;
  assign save_state_bus_load = load_q;

endmodule

// File: tb/tb_mapper_ss_sequencer.sv
// Directed bench for mapper_ss_sequencer: NUM_REGS=2, MEM_BASE=10'h3FF,
// ACK_TIMEOUT=4, with a backing-store responder of programmable ack delay.
module tb_mapper_ss_sequencer;

  localparam logic [9:0] BASE = 10'h3FF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_save = 1'b0;
  logic        start_load = 1'b0;
  logic        busy, done, error;
  logic        mem_req, mem_we, mem_ack;
  logic [9:0]  mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic [9:0]  ss_addr;
  logic [63:0] ss_din, ss_dout;
  logic        ss_wren, ss_rst, ss_load;

  logic        ack_en = 1'b1;
  logic [7:0]  ack_lat = 8'd1;
  logic [7:0]  wait_cnt = 8'd0;

  int n_checks = 0;
  int n_fail   = 0;

  // Event logs: code {done,load,wren,rst}, save_state_bus writes, mem writes.
  logic [3:0]  ev_log  [64];
  logic [9:0]  wr_addr [64];
  logic [63:0] wr_din  [64];
  logic [9:0]  mw_addr [64];
  logic [63:0] mw_data [64];
  logic [5:0]  ev_ptr = 6'd0;
  logic [5:0]  wr_ptr = 6'd0;
  logic [5:0]  mw_ptr = 6'd0;

  mapper_ss_sequencer #(
    .NUM_REGS    (2),
    .MEM_BASE    (BASE),
    .ACK_TIMEOUT (4)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .start_save          (start_save),
    .start_load          (start_load),
    .busy                (busy),
    .done                (done),
    .error               (error),
    .mem_req             (mem_req),
    .mem_we              (mem_we),
    .mem_addr            (mem_addr),
    .mem_wdata           (mem_wdata),
    .mem_rdata           (mem_rdata),
    .mem_ack             (mem_ack),
    .save_state_bus_addr (ss_addr),
    .save_state_bus_din  (ss_din),
    .save_state_bus_wren (ss_wren),
    .save_state_bus_rst  (ss_rst),
    .save_state_bus_load (ss_load),
    .save_state_bus_dout (ss_dout)
  );

  always #5 clk = ~clk;

  // Mapper slot contents and backing-store contents.
  assign ss_dout   = (ss_addr == 10'd0) ? 64'hA5 :
                     (ss_addr == 10'd1) ? 64'h3C : 64'h0;
  assign mem_rdata = (mem_addr == 10'h3FF) ? 64'h11 :
                     (mem_addr == 10'h000) ? 64'h22 : 64'hDEAD;

  // Ack responder: ack after ack_lat waiting cycles.
  assign mem_ack = ack_en && mem_req && (wait_cnt >= ack_lat);
  always @(posedge clk) wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 8'd1 : 8'd0;

  always @(posedge clk) begin
    if (!reset) begin
      if (ss_rst || ss_wren || ss_load || done) begin
        ev_log[ev_ptr] <= {done, ss_load, ss_wren, ss_rst};
        ev_ptr <= ev_ptr + 6'd1;
      end
      if (ss_wren) begin
        wr_addr[wr_ptr] <= ss_addr;
        wr_din[wr_ptr]  <= ss_din;
        wr_ptr <= wr_ptr + 6'd1;
      end
      if (mem_req && mem_ack && mem_we) begin
        mw_addr[mw_ptr] <= mem_addr;
        mw_data[mw_ptr] <= mem_wdata;
        mw_ptr <= mw_ptr + 6'd1;
      end
    end
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic s, input logic l);
    @(negedge clk);
    start_save = s;
    start_load = l;
    @(negedge clk);
    start_save = 1'b0;
    start_load = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!busy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check_val(tag, 64'(ok), 64'd1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_busy"},  64'(busy), 64'd0);
    check_val({tag, "_done"},  64'(done), 64'd0);
    check_val({tag, "_error"}, 64'(error), 64'd0);
    check_val({tag, "_req"},   64'(mem_req), 64'd0);
    check_val({tag, "_we"},    64'(mem_we), 64'd0);
    check_val({tag, "_maddr"}, 64'(mem_addr), 64'h3FF);
    check_val({tag, "_wdata"}, mem_wdata, 64'd0);
    check_val({tag, "_saddr"}, 64'(ss_addr), 64'd0);
    check_val({tag, "_din"},   ss_din, 64'd0);
    check_val({tag, "_strb"},  64'({ss_wren, ss_rst, ss_load}), 64'd0);
  endtask

  // Save of both slots; expects writes (3FF,A5),(000,3C) and a lone done.
  task automatic check_save(input string tag, input logic [5:0] b_ev, input logic [5:0] b_mw);
    check_val({tag, "_nwr"},   64'(mw_ptr - b_mw), 64'd2);
    check_val({tag, "_a0"},    64'(mw_addr[b_mw]), 64'h3FF);
    check_val({tag, "_d0"},    mw_data[b_mw], 64'hA5);
    check_val({tag, "_a1"},    64'(mw_addr[b_mw + 6'd1]), 64'h000);
    check_val({tag, "_d1"},    mw_data[b_mw + 6'd1], 64'h3C);
    check_val({tag, "_nev"},   64'(ev_ptr - b_ev), 64'd1);
    check_val({tag, "_ev"},    64'(ev_log[b_ev]), 64'h8);
    check_val({tag, "_error"}, 64'(error), 64'd0);
  endtask

  initial begin
    logic [5:0] b_ev, b_mw, b_wr;
    int lat, req_cyc;
    bit found;

    // Reset state, during and after reset.
    @(negedge clk);
    check_outputs_zero("rst_hold");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_outputs_zero("rst_rel");

    // Save with zero-wait ack: latency 3*2+2 counting start and done cycles.
    ack_lat = 8'd0;
    b_ev = ev_ptr; b_mw = mw_ptr;
    @(negedge clk);
    start_save = 1'b1;
    lat = 1;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start_save = 1'b0;
      lat++;
      if (done) begin found = 1'b1; break; end
    end
    check_val("save0_done_seen", 64'(found), 64'd1);
    check_val("save0_latency", 64'(lat), 64'd8);
    check_val("save0_busy_at_done", 64'(busy), 64'd1);
    wait_idle("save0_idle");
    check_save("save0", b_ev, b_mw);

    // Save with ack one cycle after req.
    ack_lat = 8'd1;
    b_ev = ev_ptr; b_mw = mw_ptr;
    start_op(1'b1, 1'b0);
    wait_idle("save1_idle");
    check_save("save1", b_ev, b_mw);

    // Load: rst, wren x2, load, done in that order.
    b_ev = ev_ptr; b_wr = wr_ptr;
    start_op(1'b0, 1'b1);
    wait_idle("load_idle");
    check_val("load_nev", 64'(ev_ptr - b_ev), 64'd5);
    check_val("load_ev0_rst",  64'(ev_log[b_ev]),         64'h1);
    check_val("load_ev1_wren", 64'(ev_log[b_ev + 6'd1]),  64'h2);
    check_val("load_ev2_wren", 64'(ev_log[b_ev + 6'd2]),  64'h2);
    check_val("load_ev3_load", 64'(ev_log[b_ev + 6'd3]),  64'h4);
    check_val("load_ev4_done", 64'(ev_log[b_ev + 6'd4]),  64'h8);
    check_val("load_wa0", 64'(wr_addr[b_wr]), 64'd0);
    check_val("load_wd0", wr_din[b_wr], 64'h11);
    check_val("load_wa1", 64'(wr_addr[b_wr + 6'd1]), 64'd1);
    check_val("load_wd1", wr_din[b_wr + 6'd1], 64'h22);
    check_val("load_error", 64'(error), 64'd0);

    // Both starts together, then start_load while busy: save only.
    b_ev = ev_ptr; b_mw = mw_ptr;
    start_op(1'b1, 1'b1);
    @(negedge clk);
    start_load = 1'b1;
    @(negedge clk);
    start_load = 1'b0;
    wait_idle("both_idle");
    check_save("both", b_ev, b_mw);

    // Ack never comes: req high for 4 cycles, then error, idle, no done.
    ack_en = 1'b0;
    b_ev = ev_ptr;
    start_op(1'b1, 1'b0);
    req_cyc = 0;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (mem_req) req_cyc++;
      if (!busy) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check_val("tmo_ended", 64'(found), 64'd1);
    check_val("tmo_req_cycles", 64'(req_cyc), 64'd4);
    check_val("tmo_error", 64'(error), 64'd1);
    check_val("tmo_busy", 64'(busy), 64'd0);
    check_val("tmo_req", 64'(mem_req), 64'd0);
    check_val("tmo_nev", 64'(ev_ptr - b_ev), 64'd0);
    @(negedge clk);
    @(negedge clk);
    check_val("tmo_error_sticky", 64'(error), 64'd1);

    // Next accepted start clears error.
    ack_en = 1'b1;
    b_ev = ev_ptr; b_mw = mw_ptr;
    start_op(1'b1, 1'b0);
    check_val("clr_error", 64'(error), 64'd0);
    wait_idle("clr_idle");
    check_save("clr", b_ev, b_mw);

    // Reset during L_RD of slot 1.
    ack_lat = 8'd3;
    b_ev = ev_ptr;
    start_op(1'b0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (mem_req && ss_addr == 10'd1) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check_val("mid_reached_lrd1", 64'(found), 64'd1);
    reset = 1'b1;
    #1;
    check_outputs_zero("mid_rst");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("mid_nev", 64'(ev_ptr - b_ev), 64'd2);
    check_val("mid_ev1_wren", 64'(ev_log[b_ev + 6'd1]), 64'h2);
    check_val("mid_busy", 64'(busy), 64'd0);

    // Save after the abort completes normally.
    ack_lat = 8'd1;
    b_ev = ev_ptr; b_mw = mw_ptr;
    start_op(1'b1, 1'b0);
    wait_idle("post_idle");
    check_save("post", b_ev, b_mw);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
